// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM that drives a 3-entry register bank and an ALU.
// Optional ACC_CHAIN_EN: reuse the accumulator as operand 1 (skips LOAD_A).
//
// Ports:
//   Clock, Reset        posedge clock, synchronous active-high reset
//   Start, Chain        request / chain-on-accumulator (sampled in IDLE)
//   Op, OperandA/B      operation and operands, captured with Start
//   AluResult           combinational ALU output fed from the bank reads
//   AluOp               captured opcode to the ALU
//   IdReg, Escrita      bank write index / write enable, Dado = write data
//   Fonte1, Fonte2      bank read indices (2'b11 = unmapped, bank holds)
//   Busy, Done          operation in flight / one-cycle completion pulse
//   Resultado           last accumulator value, updated on entry to DONE
module calc_sequencer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Chain,
    input  logic [OPW-1:0]   Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic [WIDTH-1:0] AluResult,
    output logic [OPW-1:0]   AluOp,
    output logic [1:0]       IdReg,
    output logic [1:0]       Fonte1,
    output logic [1:0]       Fonte2,
    output logic             Escrita,
    output logic [WIDTH-1:0] Dado,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Resultado
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_READ,
        S_EXEC,
        S_WRITE_ACC,
        S_DONE
    } state_t;

    localparam logic [1:0] REG_A    = 2'b00;
    localparam logic [1:0] REG_B    = 2'b01;
    localparam logic [1:0] REG_ACC  = 2'b10;
    localparam logic [1:0] REG_NONE = 2'b11;

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             chain_q, chain_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] resultado_q, resultado_d;
    logic             acc_valid_q, acc_valid_d;

    logic chain_ok;

`ifdef ACC_CHAIN_EN
    // Chaining only makes sense once the accumulator holds a real result.
    assign chain_ok = Chain & acc_valid_q;
`else
    logic unused_chain;
    assign unused_chain = ^{Chain, acc_valid_q};
    assign chain_ok     = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            chain_q     <= 1'b0;
            res_q       <= '0;
            resultado_q <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            chain_q     <= chain_d;
            res_q       <= res_d;
            resultado_q <= resultado_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        chain_d     = chain_q;
        res_d       = res_q;
        resultado_d = resultado_q;
        acc_valid_d = acc_valid_q;

        Escrita = 1'b0;
        IdReg   = REG_NONE;
        Fonte1  = REG_NONE;
        Fonte2  = REG_NONE;
        Dado    = '0;
        Busy    = 1'b1;
        Done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    op_d    = Op;
                    a_d     = OperandA;
                    b_d     = OperandB;
                    chain_d = chain_ok;
                    state_d = chain_ok ? S_LOAD_B : S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                Escrita = 1'b1;
                IdReg   = REG_A;
                Dado    = a_q;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                Escrita = 1'b1;
                IdReg   = REG_B;
                Dado    = b_q;
                state_d = S_READ;
            end
            // READ and EXEC present identical read indices so the
            // bank's posedge read is the same whichever edge it uses.
            S_READ: begin
                Fonte1  = chain_q ? REG_ACC : REG_A;
                Fonte2  = REG_B;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                Fonte1  = chain_q ? REG_ACC : REG_A;
                Fonte2  = REG_B;
                res_d   = AluResult;
                state_d = S_WRITE_ACC;
            end
            S_WRITE_ACC: begin
                Escrita     = 1'b1;
                IdReg       = REG_ACC;
                Dado        = res_q;
                acc_valid_d = 1'b1;
                resultado_d = res_q;
                state_d     = S_DONE;
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                Busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign AluOp     = op_q;
    assign Resultado = resultado_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: bench for calc_sequencer with a register-bank and ALU
// model; expected results are queued at Start and checked on Done.
module tb_calc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Chain;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [31:0] AluResult;
    logic [1:0]  AluOp;
    logic [1:0]  IdReg;
    logic [1:0]  Fonte1;
    logic [1:0]  Fonte2;
    logic        Escrita;
    logic [31:0] Dado;
    logic        Busy;
    logic        Done;
    logic [31:0] Resultado;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  waddr_q[$];
    logic [31:0] wdata_q[$];

    logic [31:0] bank[0:3];
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;

    calc_sequencer #(.WIDTH(32), .OPW(2)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .Chain(Chain),
        .Op(Op),
        .OperandA(OperandA),
        .OperandB(OperandB),
        .AluResult(AluResult),
        .AluOp(AluOp),
        .IdReg(IdReg),
        .Fonte1(Fonte1),
        .Fonte2(Fonte2),
        .Escrita(Escrita),
        .Dado(Dado),
        .Busy(Busy),
        .Done(Done),
        .Resultado(Resultado)
    );

    always #5 Clock = ~Clock;

    // ALU: 0 add, 1 sub, 2 and, 3 or
    always_comb begin
        AluResult = '0;
        case (AluOp)
            2'd0: AluResult = rd1 + rd2;
            2'd1: AluResult = rd1 - rd2;
            2'd2: AluResult = rd1 & rd2;
            default: AluResult = rd1 | rd2;
        endcase
    end

    // Bank reads on posedge when not writing; unmapped index holds.
    always @(posedge Clock) begin
        if (Escrita === 1'b0) begin
            if (Fonte1 != 2'b11) rd1 <= bank[Fonte1];
            if (Fonte2 != 2'b11) rd2 <= bank[Fonte2];
        end
    end

    // Bank writes on negedge, plus protocol monitor and scoreboard.
    always @(negedge Clock) begin
        logic [31:0] e;
        if (Escrita === 1'b1) begin
            total++;
            if (IdReg === 2'b11 || Busy !== 1'b1 || Done !== 1'b0) begin
                bad++;
                $display("FAIL write_state: id=%b busy=%b done=%b",
                         IdReg, Busy, Done);
            end else begin
                bank[IdReg] = Dado;
                waddr_q.push_back(IdReg);
                wdata_q.push_back(Dado);
            end
        end else begin
            total++;
            if (Dado !== 32'd0) begin
                bad++;
                $display("FAIL dado_idle: got=%h want=0", Dado);
            end
        end
        if (Busy === 1'b0) begin
            total++;
            if (Escrita !== 1'b0 || Fonte1 !== 2'b11 || Fonte2 !== 2'b11) begin
                bad++;
                $display("FAIL idle_bank: esc=%b f1=%b f2=%b want 0/11/11",
                         Escrita, Fonte1, Fonte2);
            end
        end
        if (Done === 1'b1) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: res=%0d", Resultado);
            end else begin
                e = exp_q.pop_front();
                if (Resultado !== e) begin
                    bad++;
                    $display("FAIL sb_result: got=%0d want=%0d", Resultado, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ch,
                         input logic [31:0] exp, input bit push);
        Op       = op;
        OperandA = a;
        OperandB = b;
        Chain    = ch;
        Start    = 1'b1;
        if (push) exp_q.push_back(exp);
    endtask

    // Counts edges from the one that samples Start to the one entering DONE.
    task automatic wait_done(input int max, output int edges);
        edges = -1;
        for (int i = 1; i <= max && edges < 0; i++) begin
            tick();
            Start = 1'b0;
            if (Done === 1'b1) edges = i;
        end
        if (edges < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no Done within %0d edges", max);
        end
    endtask

    task automatic test_reset();
        int d0;
        Reset = 1'b1;
        Start = 1'b0;
        Chain = 1'b0;
        Op = '0;
        OperandA = '0;
        OperandB = '0;
        repeat (2) tick();
        Reset = 1'b0;
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy_done: got=%b%b want=00", Busy, Done);
        end
        total++;
        if (Escrita !== 1'b0 || IdReg !== 2'b11 || Dado !== 32'd0) begin
            bad++;
            $display("FAIL rst_write: esc=%b id=%b dado=%h", Escrita, IdReg, Dado);
        end
        total++;
        if (AluOp !== 2'b00 || Resultado !== 32'd0) begin
            bad++;
            $display("FAIL rst_regs: aluop=%b res=%h want 0", AluOp, Resultado);
        end
        // abort an operation in EXEC
        d0 = done_cnt;
        issue(2'd1, 32'd9, 32'd4, 1'b0, 32'd0, 1'b0);
        tick();
        Start = 1'b0;
        repeat (3) tick();
        total++;
        if (Busy !== 1'b1 || Escrita !== 1'b0 || Fonte1 !== 2'b00
            || Fonte2 !== 2'b01 || AluOp !== 2'd1) begin
            bad++;
            $display("FAIL exec_state: busy=%b esc=%b f1=%b f2=%b op=%b",
                     Busy, Escrita, Fonte1, Fonte2, AluOp);
        end
        Reset = 1'b1;
        tick();
        total++;
        if (Busy !== 1'b0 || Escrita !== 1'b0 || Fonte1 !== 2'b11
            || AluOp !== 2'b00 || Resultado !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b esc=%b f1=%b op=%b res=%h",
                     Busy, Escrita, Fonte1, AluOp, Resultado);
        end
        tick();
        Reset = 1'b0;
        repeat (8) tick();
        total++;
        if (done_cnt != d0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: dones=%0d want=%0d busy=%b",
                     done_cnt - d0, 0, Busy);
        end
    endtask

    task automatic test_basic();
        int edges;
        waddr_q.delete();
        wdata_q.delete();
        issue(2'd0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b1);
        wait_done(12, edges);
        total++;
        if (edges != 6) begin
            bad++;
            $display("FAIL basic_latency: got=%0d want=6", edges);
        end
        total++;
        if (Resultado !== 32'd12 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_result: got=%0d busy=%b want=12 busy=1",
                     Resultado, Busy);
        end
        total++;
        if (waddr_q.size() != 3) begin
            bad++;
            $display("FAIL basic_wcount: got=%0d want=3", waddr_q.size());
        end else begin
            total++;
            if (waddr_q[0] !== 2'b00 || wdata_q[0] !== 32'd5
                || waddr_q[1] !== 2'b01 || wdata_q[1] !== 32'd7
                || waddr_q[2] !== 2'b10 || wdata_q[2] !== 32'd12) begin
                bad++;
                $display("FAIL basic_writes: %b<-%0d %b<-%0d %b<-%0d",
                         waddr_q[0], wdata_q[0], waddr_q[1], wdata_q[1],
                         waddr_q[2], wdata_q[2]);
            end
        end
        tick();
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Resultado !== 32'd12) begin
            bad++;
            $display("FAIL basic_hold: busy=%b done=%b res=%0d want 0/0/12",
                     Busy, Done, Resultado);
        end
    endtask

    task automatic test_chain();
        int edges;
        logic [31:0] exp;
        int exp_edges;
        int exp_w;
        logic [1:0] exp_first;
`ifdef ACC_CHAIN_EN
        exp = 32'd15;
        exp_edges = 5;
        exp_w = 2;
        exp_first = 2'b01;
`else
        exp = 32'd103;
        exp_edges = 6;
        exp_w = 3;
        exp_first = 2'b00;
`endif
        waddr_q.delete();
        wdata_q.delete();
        issue(2'd0, 32'd100, 32'd3, 1'b1, exp, 1'b1);
        wait_done(12, edges);
        Chain = 1'b0;
        total++;
        if (edges != exp_edges) begin
            bad++;
            $display("FAIL chain_latency: got=%0d want=%0d", edges, exp_edges);
        end
        total++;
        if (Resultado !== exp) begin
            bad++;
            $display("FAIL chain_result: got=%0d want=%0d", Resultado, exp);
        end
        total++;
        if (waddr_q.size() != exp_w || waddr_q[0] !== exp_first) begin
            bad++;
            $display("FAIL chain_writes: count=%0d first=%b want %0d/%b",
                     waddr_q.size(), waddr_q[0], exp_w, exp_first);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int d0;
        int edges;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        issue(2'd1, 32'd100, 32'd30, 1'b0, 32'd70, 1'b1);
        // keep Start high and scramble inputs while the op runs
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            Op = 2'd3;
            OperandA = $urandom;
            OperandB = $urandom;
            if (Done === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || AluOp !== 2'd1) begin
            bad++;
            $display("FAIL b2b_done: seen=%0d aluop=%b want 1/01", seen, AluOp);
        end
        tick();
        Start = 1'b0;
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_start_in_done: busy=%b want=0", Busy);
        end
        repeat (3) tick();
        total++;
        if (done_cnt - d0 != 1 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_one_done: dones=%0d want=1 busy=%b",
                     done_cnt - d0, Busy);
        end
        issue(2'd2, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 32'h0000_00F0, 1'b1);
        wait_done(12, edges);
        total++;
        if (edges != 6 || Resultado !== 32'h0000_00F0) begin
            bad++;
            $display("FAIL b2b_second: edges=%0d res=%h want 6/000000f0",
                     edges, Resultado);
        end
        tick();
    endtask

    task automatic test_chain_after_reset();
        int edges;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        waddr_q.delete();
        wdata_q.delete();
        issue(2'd0, 32'd2, 32'd4, 1'b1, 32'd6, 1'b1);
        wait_done(12, edges);
        Chain = 1'b0;
        total++;
        if (edges != 6 || Resultado !== 32'd6) begin
            bad++;
            $display("FAIL chain_rst: edges=%0d res=%0d want 6/6", edges, Resultado);
        end
        total++;
        if (waddr_q.size() != 3 || waddr_q[0] !== 2'b00 || wdata_q[0] !== 32'd2) begin
            bad++;
            $display("FAIL chain_rst_writes: count=%0d first=%b<-%0d want 3/00<-2",
                     waddr_q.size(), waddr_q[0], wdata_q[0]);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bank[i] = '0;
        test_reset();
        test_basic();
        test_chain();
        test_back_to_back();
        test_chain_after_reset();
        repeat (2) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
